decimate_multi: RTL

// - Multi-channel, runtime-programmable decimator: for every 2**L input samples, emits one output per channel.
// - Generalises the fixed-factor keep-1-of-M decimator:
//   - per-frame selectable factor;
//   - KEEP / SUM / AVG modes;
//   - NUM_CH parallel lanes sharing one valid;
//   - partial-frame flush.
// - Sits between the front-end filter chain and downstream rate-reduced DSP; no backpressure.

---
 rtl/decimate_pkg.sv | 19 +
 rtl/decimate_lane.sv | 78 +++++++
 rtl/decimate_multi.sv | 117 +++++++++++
 3 files changed

// File: rtl/decimate_pkg.sv
// rtl/decimate_pkg.sv - shared types and helpers for the multi-channel decimator
// Purpose: decimation mode enum and output-width helper used by decimate_multi
//          and decimate_lane.
// Ports:   none (package).
package decimate_pkg;

  typedef enum logic [1:0] {
    DEC_KEEP = 2'd0,
    DEC_SUM  = 2'd1,
    DEC_AVG  = 2'd2,
    DEC_RSVD = 2'd3
  } dec_mode_t;

  // A sum of 2**max_log2 samples of 'width' bits needs max_log2 extra bits.
  function automatic int out_width(input int width, input int max_log2);
    return width + max_log2;
  endfunction

endpackage

// File: rtl/decimate_lane.sv
// rtl/decimate_lane.sv - one channel of the decimator: accumulator, keep capture, result mux
// Purpose: accumulates one channel's samples over a frame and registers the
//          KEEP / SUM / AVG result when the frame closes.
// Ports:   clk, rst          clock, synchronous active-high reset
//          i_load            first sample of a frame (loads, does not add)
//          i_add             later sample of a frame (adds to accumulator)
//          i_done            this sample closes the frame; register result
//          i_clear           flush: zero the accumulator
//          i_data            signed sample
//          i_mode, i_log2    frame configuration in effect for this sample
//          o_data            registered result, held between frames
module decimate_lane
  import decimate_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_LOG2  = 4,
  parameter int OUT_WIDTH = WIDTH + MAX_LOG2,
  parameter int LW        = $clog2(MAX_LOG2 + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_add,
  input  logic                 i_done,
  input  logic                 i_clear,
  input  logic [WIDTH-1:0]     i_data,
  input  logic [1:0]           i_mode,
  input  logic [LW-1:0]        i_log2,
  output logic [OUT_WIDTH-1:0] o_data
);

  logic signed [OUT_WIDTH-1:0] r_acc;
  logic signed [OUT_WIDTH-1:0] r_keep;
  logic signed [OUT_WIDTH-1:0] r_out;

  logic signed [OUT_WIDTH-1:0] w_ext;
  logic signed [OUT_WIDTH-1:0] w_sum;
  logic signed [OUT_WIDTH-1:0] w_keep;
  logic signed [OUT_WIDTH-1:0] w_result;

  assign w_ext  = OUT_WIDTH'($signed(i_data));
  // Sample 0 of a frame starts from the sample itself, never from the stale
  // accumulator, so back-to-back frames need no idle cycle.
  assign w_sum  = i_load ? w_ext : (r_acc + w_ext);
  assign w_keep = i_load ? w_ext : r_keep;

  always_comb begin
    w_result = w_keep;
    case (dec_mode_t'(i_mode))
      DEC_SUM: w_result = w_sum;
      DEC_AVG: w_result = w_sum >>> i_log2;  // arithmetic: floor toward -inf
      default: w_result = w_keep;            // KEEP and reserved
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_keep <= '0;
      r_out  <= '0;
    end else begin
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_load || i_add) begin
        r_acc <= w_sum;
      end
      if (i_load) begin
        r_keep <= w_ext;
      end
      if (i_done) begin
        r_out <= w_result;
      end
    end
  end

  assign o_data = r_out;

endmodule

// File: rtl/decimate_multi.sv
// rtl/decimate_multi.sv - multi-channel runtime-programmable decimator top
// Purpose: emits one result per channel for every 2**L input sample sets, with
//          per-frame latched factor and KEEP/SUM/AVG mode, and partial-frame flush.
// Ports:   clk, rst     clock, synchronous active-high reset
//          valid_in     data_in holds a sample set this cycle
//          data_in      NUM_CH packed signed samples, channel 0 in LSBs
//          log2_fac     requested log2 factor (clamped to MAX_LOG2)
//          mode         0 KEEP, 1 SUM, 2 AVG, 3 behaves as KEEP
//          flush        discard the partial frame
//          valid_out    one-cycle pulse per completed frame
//          data_out     NUM_CH packed signed results, held between pulses
//          frame_err    sticky: a flush discarded accumulated samples
module decimate_multi
  import decimate_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int NUM_CH    = 2,
  parameter  int MAX_LOG2  = 4,
  localparam int OUT_WIDTH = out_width(WIDTH, MAX_LOG2),
  localparam int LW        = $clog2(MAX_LOG2 + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic [NUM_CH*WIDTH-1:0]     data_in,
  input  logic [LW-1:0]               log2_fac,
  input  logic [1:0]                  mode,
  input  logic                        flush,
  output logic                        valid_out,
  output logic [NUM_CH*OUT_WIDTH-1:0] data_out,
  output logic                        frame_err
);

  localparam int            CNT_W = MAX_LOG2;
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LOG2);

  logic [CNT_W-1:0] r_cnt;
  logic [LW-1:0]    r_log2;
  dec_mode_t        r_mode;
  logic             r_valid;
  logic             r_err;

  logic             w_start;
  logic [LW-1:0]    w_log2_req;
  logic [LW-1:0]    w_log2;
  dec_mode_t        w_mode;
  logic [CNT_W:0]   w_mask;
  logic             w_last;
  logic             w_take;
  logic             w_load;
  logic             w_add;
  logic             w_done;

  assign w_start    = (r_cnt == '0);
  assign w_log2_req = (log2_fac > MAX_L) ? MAX_L : log2_fac;

  // On the first sample of a frame the live inputs are used directly, so the
  // frame's config applies to that very sample (including L=0 pass-through).
  assign w_log2 = w_start ? w_log2_req : r_log2;
  assign w_mode = w_start ? dec_mode_t'(mode) : r_mode;

  assign w_mask = ((CNT_W+1)'(1) << w_log2) - (CNT_W+1)'(1);
  assign w_last = ({1'b0, r_cnt} == w_mask);

  assign w_take = valid_in && !flush;
  assign w_load = w_take && w_start;
  assign w_add  = w_take && !w_start;
  assign w_done = w_take && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_log2  <= '0;
      r_mode  <= DEC_KEEP;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (flush) begin
        r_cnt <= '0;
        if (r_cnt != '0) begin
          r_err <= 1'b1;
        end
      end else if (valid_in) begin
        r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
        if (w_start) begin
          r_log2 <= w_log2_req;
          r_mode <= dec_mode_t'(mode);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    decimate_lane #(
      .WIDTH    (WIDTH),
      .MAX_LOG2 (MAX_LOG2),
      .OUT_WIDTH(OUT_WIDTH),
      .LW       (LW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_add  (w_add),
      .i_done (w_done),
      .i_clear(flush),
      .i_data (data_in[g*WIDTH +: WIDTH]),
      .i_mode (w_mode),
      .i_log2 (w_log2),
      .o_data (data_out[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  assign valid_out = r_valid;
  assign frame_err = r_err;

endmodule
